// File: rtl/wam_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
// Holds the FSM state enum, the per-level base timer limits, the game
// lengths and the one-hot difficulty codes.
package wam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_ON   = 2'd2,
    ST_DONE = 2'd3
  } wam_state_e;

  localparam logic [3:0] LVL_1 = 4'b0001;
  localparam logic [3:0] LVL_2 = 4'b0010;
  localparam logic [3:0] LVL_3 = 4'b0100;
  localparam logic [3:0] LVL_4 = 4'b1000;

  localparam logic [27:0] GAP_BASE_1 = 28'd99_999_999;
  localparam logic [27:0] ON_BASE_1  = 28'd99_999_999;
  localparam logic [27:0] GAP_BASE_2 = 28'd49_999_999;
  localparam logic [27:0] ON_BASE_2  = 28'd49_999_999;
  localparam logic [27:0] GAP_BASE_3 = 28'd24_999_999;
  localparam logic [27:0] ON_BASE_3  = 28'd49_999_999;
  localparam logic [27:0] GAP_BASE_4 = 28'd12_499_999;
  localparam logic [27:0] ON_BASE_4  = 28'd24_999_999;

  localparam logic [5:0] NORMAL_POINTS   = 6'd25;
  localparam logic [5:0] EXTENDED_POINTS = 6'd50;

  typedef struct packed {
    logic [27:0] gap;
    logic [27:0] on;
  } wam_limits_t;

  // Unshifted timer limits for a difficulty code; anything not strictly
  // one-hot falls back to level 2.
  function automatic wam_limits_t level_limits(input logic [3:0] lvl);
    wam_limits_t l;
    case (lvl)
      LVL_1:   begin l.gap = GAP_BASE_1; l.on = ON_BASE_1; end
      LVL_2:   begin l.gap = GAP_BASE_2; l.on = ON_BASE_2; end
      LVL_3:   begin l.gap = GAP_BASE_3; l.on = ON_BASE_3; end
      LVL_4:   begin l.gap = GAP_BASE_4; l.on = ON_BASE_4; end
      default: begin l.gap = GAP_BASE_2; l.on = ON_BASE_2; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/wam_light_picker.sv
// Chooses the next mole: folds a random nibble into 0..NUM_LIGHTS-1 and
// steps past the previously lit mole so the same LED never lights twice
// in a row. Purely combinational; the previous index lives in the parent.
module wam_light_picker #(
  parameter int NUM_LIGHTS = 9
) (
  input  logic [3:0] rand_nib,
  input  logic [3:0] prev_idx,
  output logic [3:0] idx
);

  localparam logic [3:0] N_LIGHTS = 4'(NUM_LIGHTS);

  logic [3:0] fold;

  // Fold the nibble into range, then avoid repeating the previous mole.
  always_comb begin
    fold = rand_nib;
    if (fold >= N_LIGHTS) fold = fold - N_LIGHTS;
    idx = fold;
    if (fold == prev_idx) idx = (fold == N_LIGHTS - 4'd1) ? 4'd0 : fold + 4'd1;
  end

endmodule

// File: rtl/wam_round_sequencer.sv
// Whack-a-mole round controller: alternates off gaps and lit windows,
// judges key presses as hits or misses, counts score and flicks, and
// flags game over once the latched flick total is reached.
// Optional feature macro: WAM_DEATHMATCH_EN adds a `deathmatch` input;
// when latched high at start, the first miss ends the game.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | after reset, outputs quiet, waiting for start
// ST_GAP  | all LEDs off, timer runs 0..gap_lim, then a mole is picked
// ST_ON   | one LED lit, timer runs 0..on_lim, waiting for a key
// ST_DONE | game over, score/flicks held, start begins a new game
module wam_round_sequencer
  import wam_pkg::*;
#(
  parameter int TIME_SHIFT = 0,
  parameter int NUM_LIGHTS = 9
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            difficulty,
  input  logic                  extended,
  input  logic [15:0]           rand_num,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
`ifdef WAM_DEATHMATCH_EN
  input  logic                  deathmatch,
`endif
  output logic [NUM_LIGHTS-1:0] light_mask,
  output logic                  hit,
  output logic                  miss,
  output logic [5:0]            score,
  output logic [5:0]            flicks,
  output logic                  busy,
  output logic                  game_over
);

  localparam logic [NUM_LIGHTS-1:0] MASK_ONE = {{(NUM_LIGHTS-1){1'b0}}, 1'b1};

  wam_state_e  state_q, state_d;
  logic [27:0] timer_q, timer_d;
  logic [27:0] gap_lim_q, gap_lim_d;
  logic [27:0] on_lim_q, on_lim_d;
  logic [5:0]  total_q, total_d;
  logic [3:0]  idx_q, idx_d;
  logic [5:0]  score_q, score_d;
  logic [5:0]  flicks_q, flicks_d;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;

  logic [3:0]  pick_idx;
  logic        dm_active;
  wam_limits_t lvl_lim;
  logic        unused_rand;

  assign unused_rand = ^rand_num[15:4];
  assign lvl_lim     = level_limits(difficulty);

  wam_light_picker #(
    .NUM_LIGHTS (NUM_LIGHTS)
  ) u_picker (
    .rand_nib (rand_num[3:0]),
    .prev_idx (idx_q),
    .idx      (pick_idx)
  );

`ifdef WAM_DEATHMATCH_EN
  logic dm_q, dm_d;

  // Latch the deathmatch switch together with the other game settings.
  always_comb begin
    dm_d = dm_q;
    if ((state_q == ST_IDLE || state_q == ST_DONE) && start) dm_d = deathmatch;
  end

  // Deathmatch mode register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) dm_q <= 1'b0;
    else       dm_q <= dm_d;
  end

  assign dm_active = dm_q;
`else
  assign dm_active = 1'b0;
`endif

  // Next-state, timer, judging and counter updates.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    gap_lim_d = gap_lim_q;
    on_lim_d  = on_lim_q;
    total_d   = total_q;
    idx_d     = idx_q;
    score_d   = score_q;
    flicks_d  = flicks_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_GAP;
          timer_d   = '0;
          gap_lim_d = lvl_lim.gap >> TIME_SHIFT;
          on_lim_d  = lvl_lim.on >> TIME_SHIFT;
          total_d   = extended ? EXTENDED_POINTS : NORMAL_POINTS;
          score_d   = '0;
          flicks_d  = '0;
        end
      end

      ST_GAP: begin
        if (timer_q == gap_lim_q) begin
          state_d = ST_ON;
          timer_d = '0;
          idx_d   = pick_idx;
        end else begin
          timer_d = timer_q + 28'd1;
        end
      end

      ST_ON: begin
        // A correct press wins over a timeout landing on the same cycle.
        if (key_valid) begin
          if (key_code == idx_q) hit_d  = 1'b1;
          else                   miss_d = 1'b1;
        end else if (timer_q == on_lim_q) begin
          miss_d = 1'b1;
        end

        if (hit_d || miss_d) begin
          flicks_d = flicks_q + 6'd1;
          if (hit_d) score_d = score_q + 6'd1;
          timer_d = '0;
          if (flicks_d == total_q || (miss_d && dm_active)) state_d = ST_DONE;
          else                                              state_d = ST_GAP;
        end else begin
          timer_d = timer_q + 28'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      gap_lim_q <= '0;
      on_lim_q  <= '0;
      total_q   <= '0;
      idx_q     <= '0;
      score_q   <= '0;
      flicks_q  <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      gap_lim_q <= gap_lim_d;
      on_lim_q  <= on_lim_d;
      total_q   <= total_d;
      idx_q     <= idx_d;
      score_q   <= score_d;
      flicks_q  <= flicks_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  assign light_mask = (state_q == ST_ON) ? (MASK_ONE << idx_q) : '0;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign score      = score_q;
  assign flicks     = flicks_q;
  assign busy       = (state_q == ST_GAP) || (state_q == ST_ON);
  assign game_over  = (state_q == ST_DONE);

endmodule
